// File: rtl/tile_board.sv
`default_nettype none
// ============================================================================
// Module      : tile_board
// Description : Ten-tile memory-match game: LFSR-shuffled board, pair judging
//               after a timed reveal, BCD move counter and pair tally.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_board #(
  parameter int unsigned SHOW_CYCLES = 50000000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       select,
  input  logic [9:0] SW,
  output logic [9:0] matched,
  output logic [9:0] revealed,
  output logic [2:0] reveal_val,
  output logic [3:0] moves_ones,
  output logic [3:0] moves_tens,
  output logic [2:0] pairs,
  output logic [3:0] offset,
  output logic       bad_sel,
  output logic       game_over
);

  localparam int unsigned c_TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [c_TIMER_W-1:0] c_TIMER_LOAD = c_TIMER_W'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_SECOND = 3'd2,
    S_SHOW   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [7:0]           r_lfsr;
  logic [9:0]           r_matched;
  logic [9:0]           r_revealed;
  logic [2:0]           r_reveal_val;
  logic [3:0]           r_moves_ones;
  logic [3:0]           r_moves_tens;
  logic [2:0]           r_pairs;
  logic [3:0]           r_offset;
  logic                 r_bad_sel;
  logic [3:0]           r_idx1;
  logic [3:0]           r_idx2;
  logic [c_TIMER_W-1:0] r_timer;

  logic       w_onehot;
  logic [3:0] w_sel_idx;
  logic       w_sel_ok;
  logic       w_timer_done;
  logic       w_is_pair;
  logic       w_start_game;
  logic       w_take1;
  logic       w_take2;
  logic       w_reject;
  logic       w_judge;
  logic [3:0] w_lfsr_mod;

  // Tiles i and i+offset fold onto 0..9, then adjacent positions share a value.
  function automatic logic [2:0] tile_val(input logic [3:0] idx, input logic [3:0] off);
    logic [4:0] sum;
    sum = 5'(idx) + 5'(off);
    if (sum >= 5'd10) sum = sum - 5'd10;
    return sum[3:1];
  endfunction

  assign w_onehot     = (SW != 10'd0) && ((SW & (SW - 10'd1)) == 10'd0);
  assign w_sel_ok     = w_onehot && ((SW & r_matched) == 10'd0) &&
                        ((r_state != S_SECOND) || (w_sel_idx != r_idx1));
  assign w_timer_done = (r_timer == '0);
  assign w_is_pair    = (tile_val(r_idx1, r_offset) == tile_val(r_idx2, r_offset));
  assign w_lfsr_mod   = 4'(r_lfsr % 8'd10);

  always_comb begin
    w_sel_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (SW[i]) w_sel_idx = 4'(i);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_game = 1'b0;
    w_take1      = 1'b0;
    w_take2      = 1'b0;
    w_reject     = 1'b0;
    w_judge      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_game = 1'b1;
          w_state_next = S_FIRST;
        end
      end
      S_FIRST: begin
        if (select) begin
          if (w_sel_ok) begin
            w_take1      = 1'b1;
            w_state_next = S_SECOND;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_SECOND: begin
        if (select) begin
          if (w_sel_ok) begin
            w_take2      = 1'b1;
            w_state_next = S_SHOW;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_SHOW: begin
        if (w_timer_done) begin
          w_judge      = 1'b1;
          w_state_next = (w_is_pair && (r_pairs == 3'd4)) ? S_DONE : S_FIRST;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_lfsr       <= LFSR_SEED;
      r_matched    <= '0;
      r_revealed   <= '0;
      r_reveal_val <= '0;
      r_moves_ones <= '0;
      r_moves_tens <= '0;
      r_pairs      <= '0;
      r_offset     <= '0;
      r_bad_sel    <= 1'b0;
      r_idx1       <= '0;
      r_idx2       <= '0;
      r_timer      <= '0;
    end else begin
      r_lfsr    <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_bad_sel <= w_reject;
      if (w_start_game) begin
        r_offset     <= w_lfsr_mod;
        r_matched    <= '0;
        r_revealed   <= '0;
        r_moves_ones <= '0;
        r_moves_tens <= '0;
        r_pairs      <= '0;
      end
      if (w_take1) begin
        r_idx1       <= w_sel_idx;
        r_revealed   <= SW;
        r_reveal_val <= tile_val(w_sel_idx, r_offset);
      end
      if (w_take2) begin
        r_idx2       <= w_sel_idx;
        r_revealed   <= r_revealed | SW;
        r_reveal_val <= tile_val(w_sel_idx, r_offset);
        r_timer      <= c_TIMER_LOAD;
        // Move counter saturates at 99.
        if (!((r_moves_tens == 4'd9) && (r_moves_ones == 4'd9))) begin
          if (r_moves_ones == 4'd9) begin
            r_moves_ones <= 4'd0;
            r_moves_tens <= r_moves_tens + 4'd1;
          end else begin
            r_moves_ones <= r_moves_ones + 4'd1;
          end
        end
      end else if ((r_state == S_SHOW) && !w_timer_done) begin
        r_timer <= r_timer - 1'b1;
      end
      if (w_judge) begin
        r_revealed <= '0;
        if (w_is_pair) begin
          r_matched <= r_matched | (10'd1 << r_idx1) | (10'd1 << r_idx2);
          r_pairs   <= r_pairs + 3'd1;
        end
      end
    end
  end

  assign matched    = r_matched;
  assign revealed   = r_revealed;
  assign reveal_val = r_reveal_val;
  assign moves_ones = r_moves_ones;
  assign moves_tens = r_moves_tens;
  assign pairs      = r_pairs;
  assign offset     = r_offset;
  assign bad_sel    = r_bad_sel;
  assign game_over  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/tile_board.md
TILE_BOARD -- requirements
Module: tile_board

Interface
REQ-001 Parameter SHOW_CYCLES, default 50000000; number of clock cycles a selected pair stays revealed before it is judged.
REQ-002 Parameter LFSR_SEED, default 8'hA5; value loaded into the shuffle LFSR on reset.
REQ-003 CLOCK_50  in  1; the only clock; all logic is on its rising edge.
REQ-004 reset  in  1; synchronous, active-high.
REQ-005 start  in  1; single-cycle pulse that shuffles the board and begins a game.
REQ-006 select  in  1; single-cycle pulse that commits the tile chosen on SW.
REQ-007 SW  in  10; one-hot tile choice; bit i selects tile i.
REQ-008 matched  out  10; bit i is high once tile i has been matched.
REQ-009 revealed  out  10; tiles currently face-up (first pick, or both picks).
REQ-010 reveal_val  out  3; value of the most recently accepted tile.
REQ-011 moves_ones, moves_tens  out  4 each; BCD count of completed pair attempts.
REQ-012 pairs  out  3; number of matched pairs, 0-5.
REQ-013 offset  out  4; shuffle offset captured at start, 0-9.
REQ-014 bad_sel  out  1; one-cycle pulse when a select is rejected.
REQ-015 game_over  out  1; high in the DONE state.

Function
REQ-016 The 8-bit Fibonacci LFSR runs free every cycle in all states: shift left, bit0 = b7^b5^b4^b3.
REQ-017 The tile value is value(i) = ((i + offset) mod 10) >> 1, giving five pairs with values 0-4.
REQ-018 The FSM has five states: IDLE, FIRST, SECOND, SHOW and DONE.
REQ-019 IDLE + start -> FIRST next cycle:
  - offset <= lfsr mod 10;
  - matched, revealed, moves and pairs cleared.
REQ-020 A select is valid only if:
  - SW is exactly one-hot;
  - the chosen tile is not matched;
  - in SECOND, the chosen tile differs from the first pick.
REQ-021 Any other select in FIRST or SECOND is ignored and produces bad_sel = 1 for exactly one cycle.
REQ-022 Valid select in FIRST:
  - latch idx1;
  - revealed = SW;
  - reveal_val = value(idx1);
  - -> SECOND.
REQ-023 Valid select in SECOND:
  - latch idx2;
  - revealed |= SW;
  - reveal_val = value(idx2);
  - moves increments in BCD (09 -> 10), saturating at 99;
  - load timer = SHOW_CYCLES - 1;
  - -> SHOW.
REQ-024 In SHOW:
  - the timer decrements each cycle and selects are ignored with no bad_sel;
  - when the timer reaches 0, next cycle: if value(idx1) == value(idx2), set both matched bits and pairs += 1;
  - revealed is cleared;
  - if pairs becomes 5 -> DONE, else -> FIRST.
REQ-025 DONE holds every output stable with game_over = 1; start -> FIRST, handled as in REQ-019.
REQ-026 start outside IDLE and DONE is ignored.
REQ-027 If start and select arrive in the same cycle in IDLE or DONE, start wins and the select is dropped without bad_sel.
REQ-028 select in IDLE or DONE is ignored without bad_sel.
REQ-029 SHOW_CYCLES = 1 gives a one-cycle SHOW; the latency from the second select to the matched update is SHOW_CYCLES + 1 cycles.

Reset
REQ-030 reset, sampled on a clock edge, takes precedence over every other input in that cycle and may be asserted in any state, including mid-SHOW.
REQ-031 On reset:
  - state = IDLE and lfsr = LFSR_SEED;
  - matched, revealed, reveal_val, moves_ones, moves_tens, pairs, offset, bad_sel, game_over = 0;
  - idx1, idx2 and the timer are cleared.

Verification
REQ-032 Bench uses SHOW_CYCLES = 4. Reset, then start pulse -> offset equals (lfsr value at the start edge) mod 10, and matched = 0, pairs = 0, moves = 00.
REQ-033 Correct pair: select SW = tile a, then SW = its partner b -> revealed = (1<<a)|(1<<b) and moves = 01. Five cycles after the second select: matched has bits a and b set, pairs = 1, revealed = 0.
REQ-034 Mismatch: select two tiles with different values -> after 5 cycles matched is unchanged, pairs unchanged, moves incremented, state back in FIRST.
REQ-035 Invalid selects, each of which must give one bad_sel pulse and no state change:
  - SW = 10'h003;
  - SW = 0;
  - an already-matched tile;
  - the same tile twice.
REQ-036 Full game:
  - match all 5 pairs after 7 mismatches -> game_over = 1, pairs = 5, matched = 10'h3FF, moves_tens = 1, moves_ones = 2;
  - then a start pulse clears the board and returns to FIRST.
REQ-037 Reset asserted mid-SHOW -> the next cycle shows every output at 0 and state IDLE; 100 further attempts without reset leave moves saturated at 99.
